ts_stub_seq: RTL and testbench
==============================

# ts_stub_seq

Per-bunch-crossing stub read sequencer for the track-sorter front end. It accepts one crossing descriptor (stub count and base address) and loads an internal remaining-stub down-counter. It then issues one stub-memory read per cycle, decrementing the counter on each read, and streams the returned stubs downstream through a 2-entry output buffer with valid/ready backpressure. It sits between the crossing scheduler and the sorter pipeline, and owns the remaining-stub counter.

## Interface
Parameters:
- STUB_CNT_BITS, 6: width of the per-crossing stub count.
- ADDR_BITS, 8: stub-memory address width.
- STUB_BITS, 32: stub word width.
- TIMEOUT_CYC, 64: stall limit in cycles. Used only with TS_SEQ_TIMEOUT_EN.

Ports:
- clk, in, 1: fast processing clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- bx_valid, in, 1: crossing descriptor valid.
- bx_ready, out, 1: sequencer idle; descriptor accepted when bx_valid & bx_ready.
- bx_cnt, in, STUB_CNT_BITS: number of stubs in the crossing.
- bx_base, in, ADDR_BITS: address of the crossing's first stub.
- rd_en, out, 1: stub-memory read strobe.
- rd_addr, out, ADDR_BITS: read address.
- rd_data, in, STUB_BITS: memory data, valid the cycle after rd_en.
- stub_valid, out, 1: output stub valid.
- stub_ready, in, 1: downstream ready.
- stub_data, out, STUB_BITS: output stub word.
- stub_last, out, 1: marks the final stub of the crossing.
- bx_done, out, 1: one-cycle pulse when a crossing is fully delivered.
- bx_abort, out, 1: one-cycle pulse on timeout; tied 0 without the macro.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - bx_ready=1.
  - On accept: load remain←bx_cnt and addr←bx_base.
  - Go to RUN if bx_cnt≠0, else to DRAIN.
- RUN:
  - rd_en = (remain≠0) & (occ − pop < 2).
  - occ = FIFO entries + in-flight read (0..2); pop = stub_valid & stub_ready.
  - Each rd_en: remain−1, addr+1. The address wraps modulo 2^ADDR_BITS.
  - When a read is issued with remain=1, go to DRAIN.
- DRAIN:
  - No reads issued.
  - When FIFO is empty and no read is in flight: pulse bx_done, go to IDLE.
- The in-flight read's rd_data is written into the FIFO tail on the following cycle.
- stub_last is carried with each entry. It is set on the entry produced by the read issued at remain=1.
- Zero-stub crossing: no rd_en, no stub_valid; bx_done pulses 1 cycle after accept.
- The counter never decrements below 0. A decrement with remain=0 is ignored.
- Simultaneous FIFO push and pop are legal; occupancy is unchanged.
- rst_n low at any time, including mid-crossing:
  - Immediately forces IDLE and empties the FIFO.
  - Clears remain, addr and the in-flight flag.
  - Returns bx_ready to 1 and all other outputs to 0; stub_data=0.
  - Any in-flight read is discarded.

## Timing
- Accept at cycle t0 → first rd_en at t0+1 → rd_data at t0+2 → stub_valid at t0+3.
- Sustained throughput is 1 stub/cycle while stub_ready=1.
- bx_done pulses on the cycle after the last stub's handshake. bx_ready=1 on the cycle after that.
- The next accept can occur on the cycle bx_ready is 1.
- Once stub_valid is asserted, stub_data and stub_last are held stable until the handshake.

## Configuration
- TS_SEQ_TIMEOUT_EN defined:
  - A stall counter counts consecutive cycles with stub_valid & !stub_ready in RUN/DRAIN.
  - When it reaches TIMEOUT_CYC: flush the FIFO, drop the remaining count, discard the in-flight read, pulse bx_abort (no bx_done), go to IDLE.
  - The stall counter clears on any handshake.
- TS_SEQ_TIMEOUT_EN undefined:
  - No stall counter.
  - bx_abort is constant 0.
  - The sequencer waits on stub_ready indefinitely.

## Structure
- Shared package (ts_pkg): STUB_CNT_BITS, state encoding localparams (IDLE/RUN/DRAIN), and the FIFO entry layout {last, data}.
- Sub-module ts_remain_cntr:
  - Loadable saturating down-counter with inputs ld_en, dec_en and init.
  - Output is_zero, combinational from the count.
  - Asynchronous active-low reset to 0.
- The 2-entry FIFO stays inline in ts_stub_seq.

## Test plan
- bx_cnt=4, bx_base=0x10, stub_ready=1 → rd_addr 0x10..0x13 on t0+1..t0+4; 4 stubs on t0+3..t0+6; stub_last on the 4th; bx_done at t0+7.
- bx_cnt=0 → no rd_en, no stub_valid; bx_done at t0+1; bx_ready at t0+2.
- bx_cnt=5, stub_ready toggling 1/0 → occ never exceeds 2; all 5 stubs delivered in order, each held stable across stalls.
- bx_base=0xFE, bx_cnt=3 → rd_addr 0xFE, 0xFF, 0x00.
- rst_n pulsed low after 2 of 6 stubs → all outputs at reset values immediately; new crossing bx_cnt=1 then completes normally.
- Macro on, TIMEOUT_CYC=8, stub_ready held 0 with the first stub pending → bx_abort 8 cycles after stub_valid rises; bx_ready=1 next cycle; no bx_done.

Source files
------------

// File: rtl/ts_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ts_pkg : shared constants for the track-sorter stub sequencer         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package ts_pkg;

    localparam int DEF_STUB_CNT_BITS = 6;

    localparam int         STATE_BITS = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    // Output FIFO entry layout is {last, data}: the last flag sits above the stub word.
    localparam int ENTRY_LAST_BITS = 1;

    function automatic int entry_bits(input int stub_bits);
        return stub_bits + ENTRY_LAST_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_remain_cntr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ts_remain_cntr : loadable saturating down-counter (remaining stubs)   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ts_remain_cntr
    import ts_pkg::*;
#(
    parameter int CNT_BITS = DEF_STUB_CNT_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_en,
    input  logic                dec_en,
    input  logic [CNT_BITS-1:0] init,
    output logic [CNT_BITS-1:0] cnt,
    output logic                is_zero
);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;

    assign is_zero = (count_q == '0);
    assign cnt     = count_q;

    // Load wins over decrement; a decrement at zero is ignored.
    always_comb begin
        count_d = count_q;
        if (ld_en) begin
            count_d = init;
        end else if (dec_en && !is_zero) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ts_stub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ts_stub_seq : per-crossing stub read sequencer with 2-entry out FIFO  |
// | Optional stall timeout/abort enabled by macro TS_SEQ_TIMEOUT_EN       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ts_stub_seq
    import ts_pkg::*;
#(
    parameter int STUB_CNT_BITS = DEF_STUB_CNT_BITS,
    parameter int ADDR_BITS     = 8,
    parameter int STUB_BITS     = 32,
    parameter int TIMEOUT_CYC   = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bx_valid,
    output logic                     bx_ready,
    input  logic [STUB_CNT_BITS-1:0] bx_cnt,
    input  logic [ADDR_BITS-1:0]     bx_base,
    output logic                     rd_en,
    output logic [ADDR_BITS-1:0]     rd_addr,
    input  logic [STUB_BITS-1:0]     rd_data,
    output logic                     stub_valid,
    input  logic                     stub_ready,
    output logic [STUB_BITS-1:0]     stub_data,
    output logic                     stub_last,
    output logic                     bx_done,
    output logic                     bx_abort
);

    localparam int ENT_BITS = entry_bits(STUB_BITS);

    logic [STATE_BITS-1:0]    state_q, state_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic                     inflight_q, inflight_d;
    logic                     inflight_last_q, inflight_last_d;
    logic [ENT_BITS-1:0]      ent0_q, ent0_d;
    logic [ENT_BITS-1:0]      ent1_q, ent1_d;
    logic [1:0]               fcnt_q, fcnt_d;

    logic [STUB_CNT_BITS-1:0] remain;
    logic                     remain_zero;
    logic                     remain_one;
    logic                     accept;
    logic                     pop;
    logic                     push;
    logic                     abort;
    logic                     rd_go;
    logic [1:0]               occ;
    logic [ENT_BITS-1:0]      push_ent;

    assign bx_ready   = (state_q == ST_IDLE);
    assign accept     = bx_valid & bx_ready;
    assign stub_valid = (fcnt_q != 2'd0);
    assign pop        = stub_valid & stub_ready;
    assign push       = inflight_q;
    assign occ        = fcnt_q + {1'b0, inflight_q};
    assign remain_one = (remain == STUB_CNT_BITS'(1));

    // Occupancy counts the in-flight read, so a read is only launched when its
    // data is guaranteed a FIFO slot on arrival.
    assign rd_go = (state_q == ST_RUN) & ~remain_zero &
                   (occ < (2'd2 + {1'b0, pop})) & ~abort;

    assign rd_en     = rd_go;
    assign rd_addr   = addr_q;
    assign push_ent  = {inflight_last_q, rd_data};
    assign stub_data = stub_valid ? ent0_q[STUB_BITS-1:0] : '0;
    assign stub_last = stub_valid & ent0_q[STUB_BITS];
    assign bx_done   = (state_q == ST_DRAIN) & (fcnt_q == 2'd0) & ~inflight_q & ~abort;
    assign bx_abort  = abort;

`ifdef TS_SEQ_TIMEOUT_EN
    localparam int STALL_BITS = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_BITS-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) || !stub_valid || stub_ready) begin
            stall_d = '0;
        end else if (stall_q != STALL_BITS'(TIMEOUT_CYC)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign abort = (state_q != ST_IDLE) & (stall_q == STALL_BITS'(TIMEOUT_CYC));
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign abort              = 1'b0;
`endif

    ts_remain_cntr #(
        .CNT_BITS (STUB_CNT_BITS)
    ) u_remain (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_en   (accept | abort),
        .dec_en  (rd_go),
        .init    (abort ? '0 : bx_cnt),
        .cnt     (remain),
        .is_zero (remain_zero)
    );

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        inflight_d      = rd_go;
        inflight_last_d = rd_go & remain_one;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = bx_base;
                    state_d = (bx_cnt != '0) ? ST_RUN : ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (rd_go) begin
                    addr_d = addr_q + 1'b1;
                    if (remain_one) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((fcnt_q == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d         = ST_IDLE;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
        end
    end

    // ent0 is always the head; a push with one entry resident lands in ent1.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        fcnt_d = fcnt_q;
        if (abort) begin
            ent0_d = '0;
            ent1_d = '0;
            fcnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fcnt_q == 2'd0) begin
                        ent0_d = push_ent;
                    end else begin
                        ent1_d = push_ent;
                    end
                    fcnt_d = fcnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    fcnt_d = fcnt_q - 2'd1;
                end
                2'b11: begin
                    if (fcnt_q == 2'd1) begin
                        ent0_d = push_ent;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            ent0_q          <= '0;
            ent1_q          <= '0;
            fcnt_q          <= 2'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            ent0_q          <= ent0_d;
            ent1_q          <= ent1_d;
            fcnt_q          <= fcnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ts_stub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ts_stub_seq : self-checking bench for ts_stub_seq                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ts_stub_seq;

    localparam int TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bx_valid = 1'b0;
    logic        bx_ready;
    logic [5:0]  bx_cnt = '0;
    logic [7:0]  bx_base = '0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        stub_valid;
    logic        stub_ready = 1'b0;
    logic [31:0] stub_data;
    logic        stub_last;
    logic        bx_done;
    logic        bx_abort;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [256];

    typedef struct {
        int cnt;
        int base;
        int rmode;    // 0: ready held 1, 1: ready toggling, 2: random ready
        int exp_lat;  // accept-to-bx_done cycles, -1 when not fixed
    } vec_t;

    typedef struct {
        logic        last;
        logic [31:0] data;
    } exp_t;

    ts_stub_seq #(
        .STUB_CNT_BITS (6),
        .ADDR_BITS     (8),
        .STUB_BITS     (32),
        .TIMEOUT_CYC   (TO_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bx_valid   (bx_valid),
        .bx_ready   (bx_ready),
        .bx_cnt     (bx_cnt),
        .bx_base    (bx_base),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .stub_valid (stub_valid),
        .stub_ready (stub_ready),
        .stub_data  (stub_data),
        .stub_last  (stub_last),
        .bx_done    (bx_done),
        .bx_abort   (bx_abort)
    );

    always #5 clk = ~clk;

    // Synchronous-read stub memory: data returns the cycle after the strobe.
    always @(posedge clk) begin
        rd_data <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bx_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bx_ready_wait", bx_ready, 1);
    endtask

    task automatic run_crossing(input int cnt, input int base, input int rmode, input int exp_lat);
        exp_t e;
        exp_t exp_q[$];
        int   addr_q[$];
        int   k, issued, popped, first_lat, done_lat, stall_run;
        logic prev_hold, prev_last;
        logic [31:0] prev_data;

        for (int i = 0; i < cnt; i++) begin
            e.data = mem[(base + i) % 256];
            e.last = (i == cnt - 1);
            exp_q.push_back(e);
            addr_q.push_back((base + i) % 256);
        end

        @(negedge clk);
        stub_ready = 1'b1;
        #1;
        wait_idle();
        bx_valid = 1'b1;
        bx_cnt   = 6'(cnt);
        bx_base  = 8'(base);

        issued = 0; popped = 0; first_lat = -1; done_lat = -1; stall_run = 0;
        prev_hold = 1'b0; prev_last = 1'b0; prev_data = '0;
        k = 0;
        while (done_lat < 0 && k < 1000) begin
            @(negedge clk);
            k++;
            bx_valid = 1'b0;
            case (rmode)
                0:       stub_ready = 1'b1;
                1:       stub_ready = (k % 2) == 1;
                default: stub_ready = (stall_run >= 3) ? 1'b1 : ($urandom_range(3) != 0);
            endcase
            #1;
            if (k == 1) chk("bx_ready_busy", bx_ready, 0);
            if (rd_en) begin
                chk("rd_expected", int'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) chk("rd_addr", rd_addr, addr_q.pop_front());
                issued++;
            end
            if (stub_valid && first_lat < 0) first_lat = k;
            if (prev_hold) begin
                chk("hold_valid", stub_valid, 1);
                chk("hold_data", stub_data, prev_data);
                chk("hold_last", stub_last, prev_last);
            end
            if (stub_valid && stub_ready) begin
                chk("stub_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("stub_data", stub_data, e.data);
                    chk("stub_last", stub_last, e.last);
                end
                popped++;
            end
            chk("occ_le_2", int'((issued - popped) <= 2), 1);
            chk("no_abort", bx_abort, 0);
            prev_hold = stub_valid & ~stub_ready;
            prev_data = stub_data;
            prev_last = stub_last;
            stall_run = prev_hold ? stall_run + 1 : 0;
            if (bx_done) done_lat = k;
        end
        chk("done_seen", int'(done_lat > 0), 1);
        chk("reads_all", addr_q.size(), 0);
        chk("stubs_all", exp_q.size(), 0);
        if (exp_lat >= 0) chk("done_lat", done_lat, exp_lat);
        if (rmode == 0 && cnt > 0) chk("first_valid_lat", first_lat, 3);
        if (cnt == 0) chk("zero_no_valid", first_lat, -1);
        @(negedge clk);
        #1;
        chk("ready_after_done", bx_ready, 1);
        chk("done_one_cycle", bx_done, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bx_ready"}, bx_ready, 1);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_stub_valid"}, stub_valid, 0);
        chk({tag, "_stub_data"}, stub_data, 0);
        chk({tag, "_stub_last"}, stub_last, 0);
        chk({tag, "_bx_done"}, bx_done, 0);
        chk({tag, "_bx_abort"}, bx_abort, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   seen, k;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        vecs[0] = '{cnt: 4,  base: 'h10, rmode: 0, exp_lat: 7};
        vecs[1] = '{cnt: 0,  base: 'h33, rmode: 0, exp_lat: 1};
        vecs[2] = '{cnt: 3,  base: 'hFE, rmode: 0, exp_lat: 6};
        vecs[3] = '{cnt: 1,  base: 'h80, rmode: 0, exp_lat: 4};
        vecs[4] = '{cnt: 63, base: 'hF0, rmode: 0, exp_lat: 66};
        vecs[5] = '{cnt: 5,  base: 'h20, rmode: 1, exp_lat: -1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_crossing(vecs[i].cnt, vecs[i].base, vecs[i].rmode, vecs[i].exp_lat);
        end

        // Reset mid-crossing after two of six stubs have been delivered.
        @(negedge clk);
        stub_ready = 1'b1;
        #1;
        wait_idle();
        bx_valid = 1'b1;
        bx_cnt   = 6'd6;
        bx_base  = 8'h50;
        seen = 0;
        k = 0;
        while (seen < 2 && k < 50) begin
            @(negedge clk);
            bx_valid = 1'b0;
            #1;
            if (stub_valid && stub_ready) seen++;
            k++;
        end
        chk("rst_pre_stubs", seen, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_crossing(1, 'h40, 0, 4);

        for (int i = 0; i < 20; i++) begin
            run_crossing(int'($urandom_range(40)), int'($urandom_range(255)), 2, -1);
        end

`ifdef TS_SEQ_TIMEOUT_EN
        @(negedge clk);
        stub_ready = 1'b0;
        #1;
        wait_idle();
        bx_valid = 1'b1;
        bx_cnt   = 6'd3;
        bx_base  = 8'h70;
        k = 0;
        while (!stub_valid && k < 20) begin
            @(negedge clk);
            bx_valid = 1'b0;
            #1;
            k++;
        end
        chk("to_valid_rise", stub_valid, 1);
        k = 0;
        while (!bx_abort && k < 40) begin
            chk("to_no_done", bx_done, 0);
            @(negedge clk);
            #1;
            k++;
        end
        chk("to_abort_lat", k, TO_CYC);
        chk("to_abort_no_done", bx_done, 0);
        @(negedge clk);
        #1;
        chk("to_ready_after", bx_ready, 1);
        chk("to_flushed", stub_valid, 0);
        chk("to_abort_pulse", bx_abort, 0);
        run_crossing(2, 'h90, 0, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
